// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register stage around a combinational multiply/divide coprocessor.
//
// Accepts mult/madd/msub/div requests, registers operands and opcode onto the
// coprocessor inputs, feeds HI/LO back as the accumulator, waits a fixed settle
// latency and then captures the coprocessor result into HI/LO.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   start, op, rs_val, rt_val   request strobe, opcode (000 mult, 001 madd, 010 msub,
//                               011 div, 1xx ignored) and operands
//   mthi_en, mtlo_en, wr_data   direct HI/LO writes, honoured only when idle
//   cop_entrada_01/02, cop_op   registered operands and opcode to the coprocessor
//   cop_hi_in, cop_lo_in        current HI/LO (accumulator inputs)
//   cop_hi_out, cop_lo_out      coprocessor result
//   hi, lo                      architectural HI/LO
//   busy                        operation in flight
//   done, div_by_zero           one-cycle completion / divide-by-zero pulses
module hilo_unit #(
    parameter int unsigned MULT_LATENCY = 4,
    parameter int unsigned DIV_LATENCY  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi_en,
    input  logic        mtlo_en,
    input  logic [31:0] wr_data,
    output logic [31:0] cop_entrada_01,
    output logic [31:0] cop_entrada_02,
    output logic [2:0]  cop_op,
    output logic [31:0] cop_hi_in,
    output logic [31:0] cop_lo_in,
    input  logic [31:0] cop_hi_out,
    input  logic [31:0] cop_lo_out,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic {StIdle, StExec} state_e;

    // Counter is loaded with LAT-1 so capture lands exactly LAT edges after acceptance.
    localparam logic [5:0] MultCnt = 6'(MULT_LATENCY - 1);
    localparam logic [5:0] DivCnt  = 6'(DIV_LATENCY - 1);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [2:0]  opc_q, opc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        opc_d   = opc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !op[2]) begin
                    // Any legal request (including div by zero) drops a same-cycle mt write.
                    if (op == 3'b011 && rt_val == 32'd0) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        opa_d   = rs_val;
                        opb_d   = rt_val;
                        opc_d   = op;
                        cnt_d   = (op == 3'b011) ? DivCnt : MultCnt;
                        state_d = StExec;
                    end
                end else begin
                    if (mthi_en) hi_d = wr_data;
                    if (mtlo_en) lo_d = wr_data;
                end
            end
            StExec: begin
                if (cnt_q != 6'd0) begin
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    hi_d    = cop_hi_out;
                    lo_d    = cop_lo_out;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            opc_q   <= 3'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign cop_entrada_01 = opa_q;
    assign cop_entrada_02 = opb_q;
    assign cop_op         = opc_q;
    // HI/LO cannot change while busy, so the accumulator inputs are stable through EXEC.
    assign cop_hi_in      = hi_q;
    assign cop_lo_in      = lo_q;
    assign hi             = hi_q;
    assign lo             = lo_q;
    assign busy           = (state_q == StExec);
    assign done           = done_q;
    assign div_by_zero    = dbz_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: scoreboard bench for hilo_unit with a behavioural coprocessor and a
// cycle-level reference model of HI/LO, busy and the completion pulses.
module tb_hilo_unit;

    localparam int unsigned MultLat = 4;
    localparam int unsigned DivLat  = 8;

    logic        clk, reset, start, mthi_en, mtlo_en;
    logic [2:0]  op, cop_op;
    logic [31:0] rs_val, rt_val, wr_data;
    logic [31:0] cop_entrada_01, cop_entrada_02, cop_hi_in, cop_lo_in;
    logic [31:0] cop_hi_out, cop_lo_out, hi, lo;
    logic        busy, done, div_by_zero;

    hilo_unit #(
        .MULT_LATENCY(MultLat),
        .DIV_LATENCY (DivLat)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .op            (op),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .mthi_en       (mthi_en),
        .mtlo_en       (mtlo_en),
        .wr_data       (wr_data),
        .cop_entrada_01(cop_entrada_01),
        .cop_entrada_02(cop_entrada_02),
        .cop_op        (cop_op),
        .cop_hi_in     (cop_hi_in),
        .cop_lo_in     (cop_lo_in),
        .cop_hi_out    (cop_hi_out),
        .cop_lo_out    (cop_lo_out),
        .hi            (hi),
        .lo            (lo),
        .busy          (busy),
        .done          (done),
        .div_by_zero   (div_by_zero)
    );

    // Signed MIPS-style arithmetic: result as {HI, LO}.
    function automatic logic [63:0] arith(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sa, sbv, p, acc;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p   = sa * sbv;
        acc = longint'({h, l});
        case (o)
            3'b000:  return p;
            3'b001:  return acc + p;
            3'b010:  return acc - p;
            3'b011:  if (sbv == 0) return 64'd0;
                     else return {32'(sa % sbv), 32'(sa / sbv)};
            default: return 64'd0;
        endcase
    endfunction

    // Combinational coprocessor driven by the DUT's registered outputs.
    assign {cop_hi_out, cop_lo_out} = arith(cop_op, cop_entrada_01, cop_entrada_02,
                                            cop_hi_in, cop_lo_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          m_rem    = 0;  // edges left until capture; 0 means idle
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;
    logic [63:0] m_pend   = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the model and pops the scoreboard on done.
    always @(negedge clk) begin
        logic exp_done, exp_dbz;
        exp_done = (sb.size() > 0) && (sb[0].due == cyc);
        exp_dbz  = exp_done ? sb[0].dbz : 1'b0;
        chk("done", 64'(done), 64'(exp_done));
        chk("div_by_zero", 64'(div_by_zero), 64'(exp_dbz));
        if (exp_done) begin
            chk("result_hi", 64'(hi), 64'(sb[0].hi));
            chk("result_lo", 64'(lo), 64'(sb[0].lo));
            void'(sb.pop_front());
        end
        chk("busy", 64'(busy), 64'(m_rem != 0));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
        chk("cop_hi_in", 64'(cop_hi_in), 64'(m_hi));
        chk("cop_lo_in", 64'(cop_lo_in), 64'(m_lo));
    end

    // Drive one cycle of inputs, advance the model across the edge.
    task automatic step(input logic s, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic mh, input logic ml,
                        input logic [31:0] wd);
        int          n_rem;
        logic [31:0] n_hi, n_lo;
        logic [63:0] n_pend;
        logic        push;
        exp_t        e;
        start = s; op = o; rs_val = a; rt_val = b;
        mthi_en = mh; mtlo_en = ml; wr_data = wd;
        n_rem = m_rem; n_hi = m_hi; n_lo = m_lo; n_pend = m_pend; push = 1'b0;
        e = '{hi: 32'd0, lo: 32'd0, dbz: 1'b0, due: 0};
        if (m_rem != 0) begin
            n_rem = m_rem - 1;
            if (n_rem == 0) begin
                n_hi = m_pend[63:32];
                n_lo = m_pend[31:0];
            end
        end else if (s && o == 3'b011 && b == 32'd0) begin
            push = 1'b1;
            e    = '{hi: m_hi, lo: m_lo, dbz: 1'b1, due: cyc + 1};
        end else if (s && o <= 3'b011) begin
            n_rem  = (o == 3'b011) ? DivLat : MultLat;
            n_pend = arith(o, a, b, m_hi, m_lo);
            push   = 1'b1;
            e      = '{hi: n_pend[63:32], lo: n_pend[31:0], dbz: 1'b0, due: cyc + 1 + n_rem};
        end else begin
            if (mh) n_hi = wd;
            if (ml) n_lo = wd;
        end
        @(posedge clk);
        cyc++;
        m_rem = n_rem; m_hi = n_hi; m_lo = n_lo; m_pend = n_pend;
        if (push) sb.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        start = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0;
        reset = 1'b1;
        m_rem = 0; m_hi = 32'd0; m_lo = 32'd0; m_pend = 64'd0;
        sb.delete();
        #1;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_op", {cop_entrada_01, cop_entrada_02}, 64'd0);
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        int          r;
        reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
        mthi_en = 1'b0; mtlo_en = 1'b0; wr_data = 32'd0;
        @(posedge clk);
        cyc++;
        #1;
        do_reset();

        // Mult: 7 * -3
        step(1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0);
        idle(MultLat);
        chk("tp_mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("tp_mult_lo", 64'(lo), 64'hFFFF_FFEB);

        // Madd: {0,5} + 3*4
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd5);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 3'b001, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0);
        idle(MultLat);
        chk("tp_madd_hi", 64'(hi), 64'd0);
        chk("tp_madd_lo", 64'(lo), 64'd17);

        // Div: -7 / 2
        step(1'b1, 3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0);
        idle(DivLat);
        chk("tp_div_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("tp_div_lo", 64'(lo), 64'hFFFF_FFFD);

        // Divide by zero leaves HI/LO alone
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hA);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hB);
        step(1'b1, 3'b011, 32'd9, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("tp_dbz_busy", 64'(busy), 64'd0);
        chk("tp_dbz_pulse", {62'd0, done, div_by_zero}, 64'd3);
        chk("tp_dbz_hilo", {hi, lo}, {32'hA, 32'hB});
        idle(2);

        // Start and mthi while busy are both ignored
        step(1'b1, 3'b000, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0);
        step(1'b1, 3'b011, 32'd9, 32'd3, 1'b1, 1'b0, 32'h55);
        idle(MultLat - 1);
        chk("tp_coll_hi", 64'(hi), 64'd0);
        chk("tp_coll_lo", 64'(lo), 64'd15);

        // Back-to-back: new start in the done cycle
        step(1'b1, 3'b000, 32'd2, 32'd3, 1'b0, 1'b0, 32'd0);
        idle(MultLat);
        step(1'b1, 3'b001, 32'd10, 32'd10, 1'b0, 1'b0, 32'd0);
        chk("tp_b2b_busy", 64'(busy), 64'd1);
        idle(MultLat);
        chk("tp_b2b_lo", 64'(lo), 64'd106);

        // Reset two cycles into a mult
        step(1'b1, 3'b000, 32'd100, 32'd100, 1'b0, 1'b0, 32'd0);
        idle(1);
        do_reset();
        idle(MultLat + 2);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) o[2] = 1'b0;
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (m_rem != 0)
                step(1'(r < 5), o, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom);
            else if (r < 3)
                step(1'b1, o, a, b, 1'b0, 1'b0, 32'd0);
            else if (r < 4)
                step(1'b1, 3'($urandom_range(0, 2)), a, b, 1'b1, 1'b1, $urandom);
            else if (r < 7)
                step(1'b0, o, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom);
            else
                idle(1);
        end
        idle(DivLat + 4);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sequential HI/LO register stage wrapped around the combinational multiply/divide coprocessor.
- Accepts mult/madd/msub/div requests from the integer pipeline and registers the operands and opcode onto the coprocessor inputs.
- Feeds the current HI/LO back as accumulator inputs, waits a fixed settle latency, then captures the coprocessor HI/LO results.
- Services mthi/mtlo writes and reports busy to the hazard unit so mfhi/mflo stall while an operation is in flight.

Parameters:
- MULT_LATENCY, 4: cycles from start acceptance to HI/LO capture for op 000/001/010 (legal range 1..63).
- DIV_LATENCY, 8: cycles from start acceptance to HI/LO capture for op 011 (legal range 1..63).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request strobe, sampled each rising edge.
- op  in  3  000 mult, 001 madd, 010 msub, 011 div; 1xx illegal.
- rs_val  in  32  first operand (dividend/multiplicand).
- rt_val  in  32  second operand (divisor/multiplier).
- mthi_en  in  1  write wr_data to HI.
- mtlo_en  in  1  write wr_data to LO.
- wr_data  in  32  mthi/mtlo data.
- cop_entrada_01  out  32  registered operand 1 to coprocessor.
- cop_entrada_02  out  32  registered operand 2 to coprocessor.
- cop_op  out  3  registered opcode to coprocessor.
- cop_hi_in  out  32  current HI register.
- cop_lo_in  out  32  current LO register.
- cop_hi_out  in  32  coprocessor HI result.
- cop_lo_out  in  32  coprocessor LO result.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  one-cycle pulse for div with rt_val==0.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous, active-high.
  - On reset all registers and outputs go to 0: hi, lo, cop_* operand/op registers, counter, busy, done, div_by_zero. FSM goes to IDLE.
  - Reset mid-operation aborts the operation; no HI/LO capture follows.
- FSM states: IDLE, EXEC.
- IDLE with start=1 and op in {000,001,010}:
  - Latch rs_val, rt_val and op into cop_entrada_01, cop_entrada_02, cop_op.
  - Load the 6-bit counter with MULT_LATENCY-1, go to EXEC.
- IDLE with start=1 and op=011:
  - If rt_val!=0, latch operands as above, load the counter with DIV_LATENCY-1, go to EXEC.
  - If rt_val==0, stay in IDLE and leave hi/lo unchanged. done and div_by_zero are both high for exactly the next cycle.
- IDLE with start=1 and op=1xx: ignored, no state change, no pulses.
- EXEC:
  - busy=1 for the whole state.
  - counter!=0: decrement.
  - counter==0: on that edge capture hi<=cop_hi_out and lo<=cop_lo_out, assert done for the following cycle, return to IDLE.
- Latency and throughput:
  - Start accepted at edge N; new hi/lo are visible after edge N+LAT; done is high in the same cycle they first become visible.
  - busy is high from after edge N until edge N+LAT.
  - A new start may be accepted in the same cycle done is high.
- start while busy: ignored (not queued). The in-flight operation completes unaffected.
- cop_hi_in/cop_lo_in are driven straight from hi/lo. They are stable throughout EXEC because mt writes are blocked while busy.
- mthi/mtlo:
  - Honoured only in IDLE, when no start is accepted that cycle, and take effect at the next edge. mthi_en and mtlo_en may both be high together.
  - Ignored while busy.
  - When start is accepted in the same cycle as an mt write, start wins and the mt write is dropped.
- Arithmetic: this block performs no arithmetic. Result correctness comes from the coprocessor; the block only registers and captures, all widths are 32 bits, and no truncation occurs.
- Between pulses: done and div_by_zero are 0 at all other times.

Test Plan:
- Mult: reset, start op=000 rs=7 rt=0xFFFFFFFD → busy for 4 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done high for 1 cycle.
- Madd: mtlo 5, mthi 0, then start op=001 rs=3 rt=4 → after MULT_LATENCY, hi=0, lo=17.
- Div: start op=011 rs=0xFFFFFFF9 (−7) rt=2 → after 8 cycles, lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- Divide by zero: hi=0xA, lo=0xB, start op=011 rt=0 → next cycle done=1 and div_by_zero=1, busy stays 0, hi/lo unchanged.
- Blocking and collisions:
  - During a mult, assert start op=011 and mthi_en with wr_data=0x55 → both ignored; the mult result is captured.
  - Back-to-back start in the done cycle is accepted.
- Reset mid-EXEC: assert reset 2 cycles into a mult → hi=lo=0 immediately, busy=0, no done pulse afterwards.
